seq_multiplier: RTL

Parametrised sequential unsigned multiplier: successor to the 2-bit combinational twobit_multiplier. Computes O = A*B by shift-add, one multiplier bit per clock, with a start/busy/done handshake. Used where an N-bit product is needed without an N x N array; product is registered and held until the next result.

---
 rtl/seq_multiplier.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Sequential unsigned shift-add multiplier. One multiplier bit is consumed
//   per clock, so a product takes exactly WIDTH cycles after start is accepted.
//   The product register O holds the last result until the next completion
//   or reset.
//
// Parameters
//   WIDTH : operand width in bits (>= 2); product width is 2*WIDTH
//
// Ports
//   clk   : system clock, rising-edge
//   rst   : asynchronous, active-high reset
//   start : request a multiplication (accepted only while idle)
//   A     : multiplicand, unsigned, sampled when start is accepted
//   B     : multiplier, unsigned, sampled when start is accepted
//   busy  : high while a multiplication is in progress
//   done  : one-cycle pulse, O holds a new product
//   O     : registered product, unsigned, 2*WIDTH bits
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] O
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      a_reg, a_nxt;
  logic [WIDTH-1:0]   b_reg, b_nxt;
  logic [PW-1:0]      acc, acc_nxt;
  logic [PW-1:0]      acc_sum;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               busy_nxt, done_nxt;
  logic [PW-1:0]      o_nxt;

  // Conditionally add the shifted multiplicand. The accumulator is 2*WIDTH
  // bits wide, so the sum of all partial products can never overflow.
  function automatic logic [PW-1:0] add_partial(input logic [PW-1:0] acc_v,
                                                input logic [PW-1:0] a_v,
                                                input logic          bit_v);
    return bit_v ? (acc_v + a_v) : acc_v;
  endfunction

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    acc_nxt   = acc;
    count_nxt = count;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    o_nxt     = O;
    acc_sum   = add_partial(acc, a_reg, b_reg[0]);

    case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = PW'(A);
          b_nxt     = B;
          acc_nxt   = '0;
          count_nxt = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_nxt   = acc_sum;
        a_nxt     = a_reg << 1;
        b_nxt     = b_reg >> 1;
        count_nxt = count + CNT_W'(1);
        // The last bit's partial product is folded straight into O so the
        // result appears exactly WIDTH edges after acceptance.
        if (count == CNT_W'(WIDTH - 1)) begin
          o_nxt     = acc_sum;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      O     <= '0;
    end else begin
      state <= state_nxt;
      a_reg <= a_nxt;
      b_reg <= b_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      O     <= o_nxt;
    end
  end

endmodule
